// File: rtl/noc_loopback_buffer_if.sv
// Flit channel between a compute tile and the loopback buffer.
// The master drives flit/last/valid and the slave answers with ready.
interface noc_loopback_buffer_if #(
   parameter int unsigned FLIT_WIDTH = 32
);
   logic [FLIT_WIDTH-1:0] flit;
   logic                  last;
   logic                  valid;
   logic                  ready;

   modport master (output flit, output last, output valid, input ready);
   modport slave  (input flit, input last, input valid, output ready);
endinterface

// File: rtl/noc_loopback_buffer.sv
// Store-and-forward NoC loopback: buffers whole packets, swaps header DEST/SRC, replays them.
// Define NOC_LOOPBACK_STATS_EN to add saturating packet/flit/truncation counters.
module noc_loopback_buffer #(
   parameter int unsigned FLIT_WIDTH  = 32,
   parameter int unsigned BUF_FLITS   = 16,
   parameter int unsigned MAX_PKT_LEN = 8,
   parameter int unsigned DEST_MSB    = 31,
   parameter int unsigned SRC_MSB     = 23
) (
   input  logic                  clk,
   input  logic                  rst_n,
   noc_loopback_buffer_if.slave  in_ch,
   noc_loopback_buffer_if.master out_ch,
`ifdef NOC_LOOPBACK_STATS_EN
   output logic [31:0]           stat_pkts,
   output logic [31:0]           stat_flits,
   output logic [15:0]           stat_trunc,
`endif
   output logic                  trunc_o
);
   localparam int unsigned PtrW = $clog2(BUF_FLITS);
   localparam int unsigned CntW = $clog2(MAX_PKT_LEN) + 1;

   typedef enum logic [1:0] {InHdr, InBody, InDrop} in_state_e;
   typedef enum logic [1:0] {OutIdle, OutHdr, OutBody} out_state_e;

   in_state_e             in_state_q, in_state_d;
   out_state_e            out_state_q, out_state_d;
   logic [FLIT_WIDTH:0]   mem_q [BUF_FLITS];
   logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]         fill_q, fill_d, pkt_cnt_q, pkt_cnt_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  in_ready_q, in_ready_d;
   logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic [FLIT_WIDTH-1:0] out_flit_q, out_flit_d;
   logic                  trunc_q, trunc_d;
   logic                  in_acc, out_acc, wr_en, wr_last, pkt_inc, pkt_dec, rd_en;
   logic [FLIT_WIDTH:0]   rd_entry;
   logic [FLIT_WIDTH-1:0] hdr_swapped;

   assign in_acc   = in_ch.valid && in_ready_q;
   assign out_acc  = out_valid_q && out_ch.ready;
   assign rd_entry = mem_q[rd_ptr_q];

   always_comb begin
      hdr_swapped                 = rd_entry[FLIT_WIDTH-1:0];
      hdr_swapped[DEST_MSB -: 5]  = rd_entry[SRC_MSB -: 5];
      hdr_swapped[SRC_MSB -: 5]   = rd_entry[DEST_MSB -: 5];
   end

   // Input side: store up to MAX_PKT_LEN flits, force last, then swallow the remainder.
   always_comb begin
      in_state_d = in_state_q;
      cnt_d      = cnt_q;
      wr_en      = 1'b0;
      wr_last    = 1'b0;
      pkt_inc    = 1'b0;
      trunc_d    = 1'b0;
      unique case (in_state_q)
         InHdr: if (in_acc) begin
            wr_en = 1'b1;
            if (in_ch.last) begin
               wr_last = 1'b1;
               pkt_inc = 1'b1;
            end else begin
               cnt_d      = CntW'(1);
               in_state_d = InBody;
            end
         end
         InBody: if (in_acc) begin
            wr_en = 1'b1;
            if (in_ch.last || cnt_q == CntW'(MAX_PKT_LEN - 1)) begin
               wr_last    = 1'b1;
               pkt_inc    = 1'b1;
               in_state_d = in_ch.last ? InHdr : InDrop;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         InDrop: if (in_acc && in_ch.last) begin
            trunc_d    = 1'b1;
            in_state_d = InHdr;
         end
         default: in_state_d = InHdr;
      endcase
   end

   // Output side: a packet starts only once its last flit is counted in pkt_cnt_q.
   always_comb begin
      out_state_d = out_state_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_flit_d  = out_flit_q;
      rd_en       = 1'b0;
      pkt_dec     = 1'b0;
      unique case (out_state_q)
         OutIdle: if (pkt_cnt_q != '0) begin
            rd_en       = 1'b1;
            out_flit_d  = hdr_swapped;
            out_last_d  = rd_entry[FLIT_WIDTH];
            out_valid_d = 1'b1;
            out_state_d = OutHdr;
         end
         OutHdr, OutBody: if (out_acc) begin
            if (out_last_q) begin
               pkt_dec = 1'b1;
               if (pkt_cnt_q > {{PtrW{1'b0}}, 1'b1}) begin
                  rd_en       = 1'b1;
                  out_flit_d  = hdr_swapped;
                  out_last_d  = rd_entry[FLIT_WIDTH];
                  out_state_d = OutHdr;
               end else begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  out_state_d = OutIdle;
               end
            end else begin
               rd_en       = 1'b1;
               out_flit_d  = rd_entry[FLIT_WIDTH-1:0];
               out_last_d  = rd_entry[FLIT_WIDTH];
               out_state_d = OutBody;
            end
         end
         default: out_state_d = OutIdle;
      endcase
   end

   // Fill covers the flit sitting in the output register, so it frees on accept, not on load.
   always_comb begin
      fill_d = fill_q;
      if (wr_en && !out_acc)      fill_d = fill_q + 1'b1;
      else if (!wr_en && out_acc) fill_d = fill_q - 1'b1;
      pkt_cnt_d = pkt_cnt_q;
      if (pkt_inc && !pkt_dec)      pkt_cnt_d = pkt_cnt_q + 1'b1;
      else if (!pkt_inc && pkt_dec) pkt_cnt_d = pkt_cnt_q - 1'b1;
      in_ready_d = (fill_d < (PtrW + 1)'(BUF_FLITS)) || (in_state_d == InDrop);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_state_q  <= InHdr;
         out_state_q <= OutIdle;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fill_q      <= '0;
         pkt_cnt_q   <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_flit_q  <= '0;
         trunc_q     <= 1'b0;
      end else begin
         in_state_q  <= in_state_d;
         out_state_q <= out_state_d;
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         fill_q      <= fill_d;
         pkt_cnt_q   <= pkt_cnt_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_flit_q  <= out_flit_d;
         trunc_q     <= trunc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= {wr_last, in_ch.flit};
   end

`ifdef NOC_LOOPBACK_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_pkts  <= '0;
         stat_flits <= '0;
         stat_trunc <= '0;
      end else begin
         if (out_acc && stat_flits != '1) stat_flits <= stat_flits + 1'b1;
         if (out_acc && out_last_q && stat_pkts != '1) stat_pkts <= stat_pkts + 1'b1;
         if (trunc_d && stat_trunc != '1) stat_trunc <= stat_trunc + 1'b1;
      end
   end
`endif

   assign in_ch.ready  = in_ready_q;
   assign out_ch.flit  = out_flit_q;
   assign out_ch.last  = out_last_q;
   assign out_ch.valid = out_valid_q;
   assign trunc_o      = trunc_q;
endmodule
